// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacman_pkg
// Description : Constants, direction codes and state encoding shared by the
//               Pac-Man motion, view and maze collision blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

  // One-hot facing codes: [0] right, [1] left, [2] up, [3] down
  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  // Sprite box edge length in pixels
  localparam int PM_SIZE = 30;

  // Playfield bounds for the sprite's top-left corner
  localparam logic [9:0] SCREEN_X_MIN = 10'd0;
  localparam logic [9:0] SCREEN_X_MAX = 10'd610;
  localparam logic [9:0] SCREEN_Y_MIN = 10'd0;
  localparam logic [9:0] SCREEN_Y_MAX = 10'd450;

  // Spawn point and per-frame step
  localparam logic [9:0] PM_START_X = 10'd305;
  localparam logic [9:0] PM_START_Y = 10'd345;
  localparam logic [2:0] PM_STEP    = 3'd2;

  // Motion controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_Q_WANT = 2'd1,
    ST_Q_CUR  = 2'd2,
    ST_MOVE   = 2'd3
  } pm_state_t;

  // Highest-priority pressed button as a one-hot direction (up > down > left > right)
  function automatic logic [3:0] btn_to_dir(input logic up, input logic down,
                                            input logic left, input logic right);
    if (up)         return DIR_UP;
    else if (down)  return DIR_DOWN;
    else if (left)  return DIR_LEFT;
    else if (right) return DIR_RIGHT;
    else            return DIR_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pacman_step_calc.sv
`default_nettype none
// ============================================================================
// Module      : pacman_step_calc
// Description : Combinational candidate position for one step in a given
//               direction, with horizontal tunnel wrap and vertical bounds.
// Revision    : 1.0 - initial release
// ============================================================================
module pacman_step_calc
  import pacman_pkg::*;
#(
  parameter logic [2:0] STEP  = PM_STEP,
  parameter logic [9:0] X_MIN = SCREEN_X_MIN,
  parameter logic [9:0] X_MAX = SCREEN_X_MAX,
  parameter logic [9:0] Y_MIN = SCREEN_Y_MIN,
  parameter logic [9:0] Y_MAX = SCREEN_Y_MAX
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [3:0] dir,
  output logic [9:0] cand_x,
  output logic [9:0] cand_y,
  output logic       oob
);

  // 11-bit intermediates keep the bound compares free of wrap-around
  logic [10:0] x_inc, y_inc, x_lo, y_lo;
  assign x_inc = {1'b0, x} + {8'd0, STEP};
  assign y_inc = {1'b0, y} + {8'd0, STEP};
  assign x_lo  = {1'b0, X_MIN} + {8'd0, STEP};
  assign y_lo  = {1'b0, Y_MIN} + {8'd0, STEP};

  // Pick the candidate for the requested direction; a non one-hot code never moves
  always_comb begin
    cand_x = x;
    cand_y = y;
    oob    = 1'b0;
    case (dir)
      DIR_RIGHT: cand_x = (x_inc > {1'b0, X_MAX}) ? X_MIN : x_inc[9:0];
      DIR_LEFT:  cand_x = ({1'b0, x} < x_lo) ? X_MAX : (x - {7'd0, STEP});
      DIR_UP: begin
        cand_y = y - {7'd0, STEP};
        oob    = ({1'b0, y} < y_lo);
      end
      DIR_DOWN: begin
        cand_y = y_inc[9:0];
        oob    = (y_inc > {1'b0, Y_MAX});
      end
      default: oob = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pacman_motion.sv
`default_nettype none
// ============================================================================
// Module      : pacman_motion
// Description : Per-frame Pac-Man movement controller. Latches button intent,
//               queries the maze collision block for the wanted direction
//               and then the current one, and steps the sprite.
// Revision    : 1.0 - initial release
// ============================================================================
module pacman_motion
  import pacman_pkg::*;
#(
  parameter logic [9:0] START_X = PM_START_X,
  parameter logic [9:0] START_Y = PM_START_Y,
  parameter logic [2:0] STEP    = PM_STEP,
  parameter logic [9:0] X_MIN   = SCREEN_X_MIN,
  parameter logic [9:0] X_MAX   = SCREEN_X_MAX,
  parameter logic [9:0] Y_MIN   = SCREEN_Y_MIN,
  parameter logic [9:0] Y_MAX   = SCREEN_Y_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       respawn,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       wall_req,
  output logic [9:0] wall_x,
  output logic [9:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [9:0] pm_xpos,
  output logic [9:0] pm_ypos,
  output logic [3:0] pm_direction,
  output logic       pm_moving
);

  pm_state_t  state_q, state_d;
  logic [3:0] want_q, want_d;
  logic [3:0] dir_q, dir_d;
  logic [9:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [9:0] wx_q, wx_d, wy_q, wy_d;
  logic       req_q, req_d;
  logic       moving_q, moving_d;

  logic [3:0] calc_dir;
  logic [9:0] cand_x, cand_y;
  logic       cand_oob;
  logic [3:0] btn_dir;

  // The wanted direction is only probed in Q_WANT; everything else probes the facing
  assign calc_dir = (state_q == ST_Q_WANT) ? want_q : dir_q;
  assign btn_dir  = btn_to_dir(btn_up, btn_down, btn_left, btn_right);

  pacman_step_calc #(
    .STEP  (STEP),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX)
  ) u_step_calc (
    .x      (xpos_q),
    .y      (ypos_q),
    .dir    (calc_dir),
    .cand_x (cand_x),
    .cand_y (cand_y),
    .oob    (cand_oob)
  );

  // Next-state logic: query sequencing, direction adoption, move and respawn
  always_comb begin
    state_d  = state_q;
    want_d   = want_q;
    dir_d    = dir_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    wx_d     = wx_q;
    wy_d     = wy_q;
    req_d    = req_q;
    moving_d = moving_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && enable) begin
          state_d = ((want_q != DIR_NONE) && (want_q != dir_q)) ? ST_Q_WANT : ST_Q_CUR;
        end
      end
      ST_Q_WANT: begin
        if (!req_q) begin
          if (cand_oob) begin
            state_d = ST_Q_CUR;
          end else begin
            req_d = 1'b1;
            wx_d  = cand_x;
            wy_d  = cand_y;
          end
        end else if (wall_ack) begin
          req_d = 1'b0;
          if (wall_hit) begin
            state_d = ST_Q_CUR;
          end else begin
            dir_d   = want_q;
            want_d  = DIR_NONE;
            state_d = ST_MOVE;
          end
        end
      end
      ST_Q_CUR: begin
        if (!req_q) begin
          if (cand_oob) begin
            moving_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            req_d = 1'b1;
            wx_d  = cand_x;
            wy_d  = cand_y;
          end
        end else if (wall_ack) begin
          req_d = 1'b0;
          if (wall_hit) begin
            moving_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_MOVE;
          end
        end
      end
      ST_MOVE: begin
        // The accepted candidate is still held on wall_x/wall_y
        xpos_d   = wx_q;
        ypos_d   = wy_q;
        moving_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh press is never lost, even in the cycle a direction is adopted
    if (btn_dir != DIR_NONE) begin
      want_d = btn_dir;
    end

    // Respawn abandons any query and beats a same-cycle frame tick
    if (respawn) begin
      state_d  = ST_IDLE;
      want_d   = DIR_NONE;
      dir_d    = DIR_RIGHT;
      xpos_d   = START_X;
      ypos_d   = START_Y;
      req_d    = 1'b0;
      moving_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      want_q   <= DIR_NONE;
      dir_q    <= DIR_RIGHT;
      xpos_q   <= START_X;
      ypos_q   <= START_Y;
      wx_q     <= 10'd0;
      wy_q     <= 10'd0;
      req_q    <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      want_q   <= want_d;
      dir_q    <= dir_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      req_q    <= req_d;
      moving_q <= moving_d;
    end
  end

  assign wall_req     = req_q;
  assign wall_x       = wx_q;
  assign wall_y       = wy_q;
  assign pm_xpos      = xpos_q;
  assign pm_ypos      = ypos_q;
  assign pm_direction = dir_q;
  assign pm_moving    = moving_q;

endmodule
`default_nettype wire
